split_route: RTL

Clocked two-way split: accepts a 1-bit select token, then one data token, and forwards the data to output 0 or output 1 as chosen by the select. It is the distribution counterpart of the two-input select-driven merge and sits at the NoC router fan-out. It uses the same token-per-channel semantics, but on synchronous valid/ready channels.

---
 rtl/split_pkg.sv | 13 +
 rtl/split_route.sv | 88 ++++++++
 2 files changed

// File: rtl/split_pkg.sv
// Shared types and default sizing for the split_route select-driven splitter.
package split_pkg;

    typedef enum logic [1:0] {
        WAIT_SEL  = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2
    } state_t;

    localparam int unsigned SPLIT_W  = 9;
    localparam int unsigned SPLIT_CW = 16;

endpackage

// File: rtl/split_route.sv
// Two-way split: takes a select token, then a data token, and forwards the data to
// out0 or out1; counts completed sends per output.
module split_route
    import split_pkg::*;
#(
    parameter int unsigned W  = SPLIT_W,
    parameter int unsigned CW = SPLIT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [W-1:0]  out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [W-1:0]  out1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic          r_sel;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic          w_send;
    logic          w_out_ready;

    assign w_send      = (r_state == SEND);
    // Only the selected output's ready can complete the transfer.
    assign w_out_ready = r_sel ? out1_ready : out0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_SEL;
            r_sel   <= 1'b0;
            r_data  <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            unique case (r_state)
                WAIT_SEL: begin
                    if (s_valid) begin
                        r_sel   <= s_data;
                        r_state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_out_ready) begin
                        if (r_sel) begin
                            r_cnt1 <= r_cnt1 + CntOne;
                        end else begin
                            r_cnt0 <= r_cnt0 + CntOne;
                        end
                        r_state <= WAIT_SEL;
                    end
                end
                default: r_state <= WAIT_SEL;
            endcase
        end
    end

    // Readies decode only the state, never an upstream valid.
    assign s_ready    = (r_state == WAIT_SEL);
    assign in_ready   = (r_state == WAIT_DATA);
    assign out0_valid = w_send & ~r_sel;
    assign out1_valid = w_send & r_sel;
    assign out0_data  = r_data;
    assign out1_data  = r_data;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule
